gate_model_bist: RTL
====================

# gate_model_bist

Built-in self-test driver for the simulator's 11-input/10-output combinational gate models. It generates pseudo-random input patterns from an 11-bit LFSR and drives them onto the gate model inputs N1..N11. It compacts the model's outputs into a 16-bit MISR signature and compares the signature against a golden value. It sits on the other side of the gate model: it produces every stimulus and consumes every response of the netlist under test.

## Interface
- PATTERN_COUNT, 1024: number of patterns applied per run. Legal range 1..2047, or 1..2048 with the all-zero feature enabled.
- LFSR_SEED, 11'h001: first pattern. Must be non-zero.
- SIG_SEED, 16'hFFFF: MISR initial value.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  start request; sampled only in IDLE or DONE.
- golden  in  16  expected signature; sampled while in DONE.
- resp_in  in  10  gate model outputs (bit 0 = first listed output).
- pat_out  out  11  gate model inputs (bit 0 = N1 … bit 10 = N11), registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && (signature == golden); combinational from registers.
- signature  out  16  current MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after PATTERN_COUNT RUN cycles.
  - DONE → RUN on start. DONE holds otherwise.
- On entering RUN: pat_out←LFSR_SEED, cnt←0, signature←SIG_SEED.
- Each RUN clock edge:
  - MISR absorbs resp_in, which is the response to the current pat_out.
  - pat_out←lfsr_next(pat_out).
  - cnt←cnt+1.
- LFSR (Fibonacci, x^11+x^9+1, maximal length 2047): fb = p[10]^p[8]; next = {p[9:0], fb}.
- MISR (x^16+x^12+x^5+1): m' = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {6'b0, resp_in}.
- Last RUN edge (cnt == PATTERN_COUNT-1): the last response is absorbed, the state goes to DONE, and pat_out←0.
- In IDLE and DONE, pat_out = 0 and signature holds.
- start while busy is ignored, with no queueing.
- A start in the same cycle as the final RUN edge is ignored.
- cnt is 12 bits wide and never wraps within a run.

## Timing
- Reset values (rst_n low at an edge): state IDLE, pat_out 0, busy 0, done 0, pass 0, signature SIG_SEED, cnt 0.
- Reset mid-run aborts at that edge. No partial signature is kept.
- Start accepted at edge E0:
  - busy is high from E0 to E(PATTERN_COUNT), i.e. exactly PATTERN_COUNT cycles.
  - done rises at edge E(PATTERN_COUNT).
- Pattern k (k = 0…PATTERN_COUNT-1) is visible on pat_out between E(k) and E(k+1). resp_in is sampled at E(k+1).
- The gate model must settle within one clk period.
- pass is valid the cycle done rises and tracks golden while done is high.

## Configuration
- BIST_ALLZERO_EN defined:
  - Pattern index 2047 is forced to 11'h000 instead of the LFSR value.
  - PATTERN_COUNT=2048 therefore applies all 2048 input combinations exhaustively.
  - The LFSR state is not advanced past that point.
- BIST_ALLZERO_EN undefined:
  - Pure LFSR sequence. The all-zero pattern is never applied.
  - PATTERN_COUNT > 2047 is an elaboration error via $error.

## Test plan
- Reset: hold rst_n=0 for 2 edges → pat_out=0, busy=0, done=0, pass=0, signature=16'hFFFF.
- PATTERN_COUNT=1, resp_in=0, start pulse → busy for 1 cycle, then done=1 and signature=16'hEFDF. golden=16'hEFDF → pass=1; golden=16'h0000 → pass=0.
- PATTERN_COUNT=16, start → pat_out sequence 001, 002, 004, 008, 010, 020, 040, 080, 100, 201, 402, 005, …. busy high exactly 16 cycles. pat_out=0 after done.
- Start pulses at RUN cycles 3 and 15 → ignored, run still lasts exactly 16 cycles. Start in DONE → new run, signature restarted from 16'hFFFF.
- rst_n low at RUN cycle 5, then start → identical pattern sequence and identical final signature to an uninterrupted run, with resp_in driven by a loopback model (resp_in = pat_out[9:0]).
- BIST_ALLZERO_EN, PATTERN_COUNT=2048, loopback → 2048 distinct pat_out values, final pattern 11'h000, done after 2048 cycles.

Source files
------------

// File: rtl/gate_model_bist.sv
// gate_model_bist: LFSR pattern generator + 16-bit MISR response compactor for 11-in/10-out gate models.
// Latency: pat_out registered, one pattern per clk; done rises PATTERN_COUNT cycles after start is taken.
// Backpressure: none; start is only taken in IDLE/DONE, while busy it is dropped (no queueing).
// Optional feature macro: BIST_ALLZERO_EN (pattern index 2047 forced to all-zero for exhaustive runs).
module gate_model_bist #(
   parameter int          PATTERN_COUNT = 1024,
   parameter logic [10:0] LFSR_SEED     = 11'h001,
   parameter logic [15:0] SIG_SEED      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] golden,
   input  logic [9:0]  resp_in,
   output logic [10:0] pat_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);

`ifdef BIST_ALLZERO_EN
   localparam int MAX_COUNT = 2048;
`else
   localparam int MAX_COUNT = 2047;
`endif

   localparam logic [11:0] LAST_CNT = 12'(PATTERN_COUNT - 1);

   // The LFSR has period 2047, so more patterns than that would repeat (or need the all-zero slot).
   if (PATTERN_COUNT < 1 || PATTERN_COUNT > MAX_COUNT) begin : g_bad_count
      $error("gate_model_bist: PATTERN_COUNT %0d outside 1..%0d", PATTERN_COUNT, MAX_COUNT);
   end
   // An all-zero seed would lock the LFSR at zero.
   if (LFSR_SEED == 11'h000) begin : g_bad_seed
      $error("gate_model_bist: LFSR_SEED must be non-zero");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] cnt;
   logic        accept;
   logic        last_edge;
   logic [10:0] lfsr_nxt;
   logic [10:0] pat_nxt;
   logic [15:0] misr_nxt;

   assign accept    = (state != RUN) && start;
   assign last_edge = (state == RUN) && (cnt == LAST_CNT);

   // x^11 + x^9 + 1 Fibonacci step.
   assign lfsr_nxt = {pat_out[9:0], pat_out[10] ^ pat_out[8]};

`ifdef BIST_ALLZERO_EN
   // Slot 2047 is the one value the LFSR never produces; fill it with zero and stop stepping.
   assign pat_nxt = (cnt == 12'd2046) ? 11'h000 : lfsr_nxt;
`else
   assign pat_nxt = lfsr_nxt;
`endif

   // x^16 + x^12 + x^5 + 1 shift with the 10 response bits folded into the low end.
   assign misr_nxt = {signature[14:0], 1'b0}
                   ^ (signature[15] ? 16'h1021 : 16'h0000)
                   ^ {6'b000000, resp_in};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; a start coinciding with the final RUN edge is lost because state is still RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = RUN;
         RUN:     if (last_edge) state_nxt = DONE;
         DONE:    if (start)     state_nxt = RUN;
         default:                state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
      pass = done && (signature == golden);
   end

   // Datapath: pattern, pattern counter and signature; restarted on every accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_out   <= 11'h000;
         cnt       <= 12'd0;
         signature <= SIG_SEED;
      end else if (accept) begin
         pat_out   <= LFSR_SEED;
         cnt       <= 12'd0;
         signature <= SIG_SEED;
      end else if (state == RUN) begin
         signature <= misr_nxt;
         cnt       <= cnt + 12'd1;
         pat_out   <= last_edge ? 11'h000 : pat_nxt;
      end
   end

endmodule
